// File: rtl/program_memory_loader_if.sv
// Byte-stream and program-memory write-port bundle for program_memory_loader.
//   byte_data/byte_valid : host -> loader stream byte and its qualifier
//   byte_ready           : loader -> host, byte consumed when valid & ready
//   we/waddr/wdata       : loader -> program memory write port (byte address)
// master = host/memory side, slave = loader side.
interface program_memory_loader_if;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;

  modport master (output byte_data, byte_valid, input byte_ready, we, waddr, wdata);
  modport slave  (input byte_data, byte_valid, output byte_ready, we, waddr, wdata);
endinterface

// File: rtl/program_memory_loader.sv
// Program memory loader: takes a framed byte stream (LEN_HI, LEN_LO, N*4 payload
// bytes MSB first, XOR checksum byte), writes each assembled big-endian word to
// program memory and holds the CPU in reset until the frame is verified.
// Ports:
//   clk, reset (async, active low)
//   bus            : slave side of program_memory_loader_if (stream in, write port out)
//   start_i        : 1-cycle pulse, starts a load from IDLE/DONE/ERROR
//   words_loaded_o : words written in the current frame
//   cpu_hold_o     : 1 = keep processor in reset
//   done_o/error_o : frame outcome levels, cleared by the next start_i
module program_memory_loader #(
  parameter int          MEMORY_DEPTH = 32,
  parameter int          DATA_WIDTH   = 32,
  parameter logic [31:0] BASE_ADDRESS = 32'h0040_0000
) (
  input  logic                    clk,
  input  logic                    reset,
  program_memory_loader_if.slave  bus,
  input  logic                    start_i,
  output logic [15:0]             words_loaded_o,
  output logic                    cpu_hold_o,
  output logic                    done_o,
  output logic                    error_o
);
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE, ERROR} state_e;

  localparam logic [15:0] DEPTH16 = 16'(MEMORY_DEPTH);

  state_e                  state_q, state_d;
  logic [15:0]             len_q, len_d;
  logic [DATA_WIDTH-1:0]   word_q, word_d;
  logic [1:0]              bcnt_q, bcnt_d;
  logic [7:0]              csum_q, csum_d;
  logic [15:0]             words_q, words_d;   // doubles as the write index
  logic                    we_q, we_d;
  logic [31:0]             waddr_q, waddr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic                    hold_q, hold_d, done_q, done_d, err_q, err_d;
  logic                    ready, accept;
  logic [15:0]             n_full;
  logic [DATA_WIDTH-1:0]   word_next;

  always_comb begin
    ready     = (state_q == LEN_HI) || (state_q == LEN_LO) ||
                (state_q == DATA)   || (state_q == CHECK);
    accept    = ready & bus.byte_valid;
    n_full    = {len_q[15:8], bus.byte_data};
    word_next = {word_q[DATA_WIDTH-9:0], bus.byte_data};

    state_d = state_q;
    len_d   = len_q;
    word_d  = word_q;
    bcnt_d  = bcnt_q;
    csum_d  = csum_q;
    words_d = words_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    hold_d  = hold_q;
    done_d  = done_q;
    err_d   = err_q;

    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start_i) begin
          state_d = LEN_HI;
          len_d   = '0;
          word_d  = '0;
          bcnt_d  = '0;
          csum_d  = '0;
          words_d = '0;
          hold_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      LEN_HI: if (accept) begin
        len_d[15:8] = bus.byte_data;
        state_d     = LEN_LO;
      end
      LEN_LO: if (accept) begin
        len_d = n_full;
        if (n_full > DEPTH16) begin
          state_d = ERROR;
          err_d   = 1'b1;
        end else if (n_full == 16'd0) begin
          state_d = CHECK;
        end else begin
          state_d = DATA;
        end
      end
      DATA: if (accept) begin
        word_d = word_next;
        csum_d = csum_q ^ bus.byte_data;
        bcnt_d = bcnt_q + 2'd1;
        if (bcnt_q == 2'd3) begin
          // Word complete: the write pulse is registered, so it appears the
          // cycle after the last byte even if the FSM moves to CHECK.
          we_d    = 1'b1;
          wdata_d = 32'(word_next);
          waddr_d = BASE_ADDRESS + {14'd0, words_q, 2'b00};
          words_d = words_q + 16'd1;
          if (words_q + 16'd1 == len_q) state_d = CHECK;
        end
      end
      CHECK: if (accept) begin
        if (bus.byte_data == csum_q) begin
          state_d = DONE;
          done_d  = 1'b1;
          hold_d  = 1'b0;
        end else begin
          state_d = ERROR;
          err_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      word_q  <= '0;
      bcnt_q  <= '0;
      csum_q  <= '0;
      words_q <= '0;
      we_q    <= 1'b0;
      waddr_q <= BASE_ADDRESS;
      wdata_q <= '0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      word_q  <= word_d;
      bcnt_q  <= bcnt_d;
      csum_q  <= csum_d;
      words_q <= words_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.byte_ready = ready;
  assign bus.we         = we_q;
  assign bus.waddr      = waddr_q;
  assign bus.wdata      = wdata_q;
  assign words_loaded_o = words_q;
  assign cpu_hold_o     = hold_q;
  assign done_o         = done_q;
  assign error_o        = err_q;
endmodule

// File: tb/tb_program_memory_loader.sv
// Scoreboard bench for program_memory_loader: frames are built from word lists,
// expected writes are queued when issued, and a monitor pops them on each we.
module tb_program_memory_loader;
  localparam logic [31:0] BASE  = 32'h0040_0000;
  localparam int          DEPTH = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] words_loaded;
  logic        hold, done, err;

  program_memory_loader_if bus();

  program_memory_loader #(.MEMORY_DEPTH(DEPTH), .DATA_WIDTH(32), .BASE_ADDRESS(BASE)) dut (
    .clk(clk), .reset(reset), .bus(bus), .start_i(start),
    .words_loaded_o(words_loaded), .cpu_hold_o(hold), .done_o(done), .error_o(err)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] sb[$];
  logic [31:0] wbuf[64];
  logic [63:0] mon_e;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset && bus.we) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %h data %h, expected no write", bus.waddr, bus.wdata);
      end else begin
        mon_e = sb.pop_front();
        chk("write_addr", bus.waddr, mon_e[63:32]);
        chk("write_data", bus.wdata, mon_e[31:0]);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    if (gaps) repeat ($urandom_range(0, 3)) begin
      @(negedge clk);
      bus.byte_valid = 1'b0;
    end
    @(negedge clk);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    n = 0;
    while (!bus.byte_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.byte_ready) begin
      checks++;
      errors++;
      $display("FAIL byte_accept_timeout: ready %b after %0d cycles, required 1", bus.byte_ready, n);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.byte_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, bus.byte_ready, 0);
    chk({tag, "_we"},    bus.we, 0);
    chk({tag, "_waddr"}, bus.waddr, BASE);
    chk({tag, "_wdata"}, bus.wdata, 0);
    chk({tag, "_words"}, words_loaded, 0);
    chk({tag, "_hold"},  hold, 0);
    chk({tag, "_done"},  done, 0);
    chk({tag, "_error"}, err, 0);
  endtask

  // Reference: words wbuf[0..n-1] go to BASE+4*i; checksum is XOR of payload
  // bytes; n > DEPTH is rejected after the length bytes with nothing written.
  task automatic send_frame(input int n, input bit bad, input bit gaps, input bit stray);
    logic [15:0] nn;
    logic [7:0]  cs, b;
    bit          ok;
    nn = 16'(n);
    cs = 8'h00;
    pulse_start();
    send_byte(nn[15:8], gaps);
    send_byte(nn[7:0], gaps);
    if (stray) pulse_start();
    if (n <= DEPTH) begin
      for (int i = 0; i < n; i++) begin
        sb.push_back({BASE + 32'(4 * i), wbuf[i]});
        for (int k = 0; k < 4; k++) begin
          b  = wbuf[i][31 - 8*k -: 8];
          cs = cs ^ b;
          send_byte(b, gaps);
        end
      end
      send_byte(bad ? (cs ^ 8'h01) : cs, gaps);
    end
    @(negedge clk);
    bus.byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    ok = (n <= DEPTH) && !bad;
    chk("frame_done",  done, ok);
    chk("frame_error", err, !ok);
    chk("frame_hold",  hold, !ok);
    chk("frame_words", words_loaded, (n <= DEPTH) ? n : 0);
    chk("frame_ready", bus.byte_ready, 0);
    chk("frame_writes_left", sb.size(), 0);
  endtask

  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b1;

    // Directed two-word frame, good and bad checksum.
    wbuf[0] = 32'h2008_0005;
    wbuf[1] = 32'h0109_5020;
    send_frame(2, 1'b0, 1'b0, 1'b0);
    send_frame(2, 1'b1, 1'b0, 1'b0);

    // Length errors: just over depth, and a large high byte.
    send_frame(33, 1'b0, 1'b0, 1'b0);
    send_frame(256, 1'b0, 1'b0, 1'b0);

    // Empty frame, then stray start pulses inside frames.
    send_frame(0, 1'b0, 1'b0, 1'b0);
    send_frame(0, 1'b0, 1'b0, 1'b1);
    send_frame(2, 1'b0, 1'b0, 1'b1);

    // Bytes offered while DONE are not consumed.
    @(negedge clk);
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'h55;
    repeat (4) @(negedge clk);
    chk("done_ignore_ready", bus.byte_ready, 0);
    chk("done_ignore_words", words_loaded, 2);
    chk("done_ignore_done",  done, 1);
    bus.byte_valid = 1'b0;

    // Full-depth gapped frame.
    for (int i = 0; i < DEPTH; i++) wbuf[i] = $urandom;
    send_frame(DEPTH, 1'b0, 1'b1, 1'b0);

    // Random frames.
    repeat (8) begin
      for (int i = 0; i < DEPTH; i++) wbuf[i] = $urandom;
      send_frame(int'($urandom_range(0, DEPTH + 2)), ($urandom % 4) == 0,
                 ($urandom % 2) == 1, 1'b0);
    end

    // Reset mid-DATA: one word written, then the frame is aborted.
    for (int i = 0; i < 4; i++) wbuf[i] = $urandom;
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h04, 1'b0);
    sb.push_back({BASE, wbuf[0]});
    for (int k = 0; k < 4; k++) send_byte(wbuf[0][31 - 8*k -: 8], 1'b0);
    send_byte(wbuf[1][31:24], 1'b0);
    send_byte(wbuf[1][23:16], 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_outputs("midreset");
    chk("midreset_writes_left", sb.size(), 0);
    bus.byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Recovery after reset.
    send_frame(3, 1'b0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end
endmodule
